conv3x3_filter: RTL

- Downstream stage of the line-buffer controller. Consumes one 3x3 pixel window per valid cycle and produces one filtered output pixel.
- Pipelined signed 3x3 convolution using a runtime-loadable, double-buffered kernel. The sum is normalised by an arithmetic right shift, then clamped to the pixel range.
- The output feeds the output FIFO/DMA path. The upstream interrupt is handled by software and does not pass through this block.

---
 rtl/conv3x3_filter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/conv3x3_filter.sv
// Pipelined 3x3 signed convolution with a double-buffered, runtime-loadable kernel.
// Three register stages: products, normalised sum, clamped pixel.

module conv3x3_tap #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COEF_WIDTH  = 8,
    parameter int PROD_WIDTH  = PIXEL_WIDTH + COEF_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PIXEL_WIDTH-1:0] pixel,
    input  logic [COEF_WIDTH-1:0]  coef,
    output logic [PROD_WIDTH-1:0]  prod
);
    logic signed [PROD_WIDTH-1:0] pix_ext, coef_ext, mul;

    // pixel is unsigned, coefficient is two's complement
    assign pix_ext  = $signed({{(PROD_WIDTH-PIXEL_WIDTH){1'b0}}, pixel});
    assign coef_ext = $signed({{(PROD_WIDTH-COEF_WIDTH){coef[COEF_WIDTH-1]}}, coef});
    assign mul      = pix_ext * coef_ext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) prod <= '0;
        else       prod <= mul;
    end
endmodule

module conv3x3_filter #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COEF_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [9*PIXEL_WIDTH-1:0] i_pixel_data,
    input  logic                     i_pixel_data_valid,
    input  logic [COEF_WIDTH-1:0]    i_coef_data,
    input  logic                     i_coef_valid,
    input  logic                     i_coef_restart,
    input  logic [SHIFT_WIDTH-1:0]   i_norm_shift,
    output logic [PIXEL_WIDTH-1:0]   o_convolved_data,
    output logic                     o_convolved_data_valid,
    output logic                     o_kernel_update,
    output logic                     o_sat
);
    localparam int TAPS       = 9;
    localparam int STAGES     = 3;
    localparam int PROD_WIDTH = PIXEL_WIDTH + COEF_WIDTH + 1;
    localparam int SUM_WIDTH  = PROD_WIDTH + 4;
    localparam logic [TAPS*COEF_WIDTH-1:0] IDENTITY =
        {{(4*COEF_WIDTH){1'b0}}, COEF_WIDTH'(1), {(4*COEF_WIDTH){1'b0}}};

    logic [TAPS-1:0][COEF_WIDTH-1:0] shadow, active;
    logic [3:0]                      idx;
    logic [STAGES:1]                 vld_pipe;
    logic [TAPS-1:0][PROD_WIDTH-1:0] prod;
    logic signed [SUM_WIDTH-1:0]     sum, norm;
    logic [PIXEL_WIDTH-1:0]          pix_c;
    logic                            sat_c;
    logic                            kernel_update;

    // Kernel load: the ninth write commits shadow plus the incoming coefficient,
    // so a window sampled on that same edge still sees the previous kernel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx           <= '0;
            shadow        <= IDENTITY;
            active        <= IDENTITY;
            kernel_update <= 1'b0;
        end else begin
            kernel_update <= 1'b0;
            if (i_coef_restart) begin
                idx    <= '0;
                shadow <= IDENTITY;
            end else if (i_coef_valid) begin
                for (int k = 0; k < TAPS; k++)
                    if (idx == 4'(k)) shadow[k] <= i_coef_data;
                if (idx == 4'(TAPS-1)) begin
                    idx <= '0;
                    for (int k = 0; k < TAPS-1; k++) active[k] <= shadow[k];
                    active[TAPS-1] <= i_coef_data;
                    kernel_update  <= 1'b1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    assign o_kernel_update = kernel_update;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        conv3x3_tap #(
            .PIXEL_WIDTH(PIXEL_WIDTH),
            .COEF_WIDTH (COEF_WIDTH),
            .PROD_WIDTH (PROD_WIDTH)
        ) u_tap (
            .i_clk(i_clk),
            .i_rst(i_rst),
            .pixel(i_pixel_data[k*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .coef (active[k]),
            .prod (prod[k])
        );
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++)
            sum = sum + $signed({{(SUM_WIDTH-PROD_WIDTH){prod[k][PROD_WIDTH-1]}}, prod[k]});
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
            norm     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], i_pixel_data_valid};
            norm     <= sum >>> i_norm_shift;
        end
    end

    always_comb begin
        pix_c = norm[PIXEL_WIDTH-1:0];
        sat_c = 1'b0;
        if (norm[SUM_WIDTH-1]) begin
            pix_c = '0;
            sat_c = 1'b1;
        end else if (|norm[SUM_WIDTH-2:PIXEL_WIDTH]) begin
            pix_c = '1;
            sat_c = 1'b1;
        end
    end

    // Output pixel holds between valid cycles; saturation flag only rides with valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_convolved_data <= '0;
            o_sat            <= 1'b0;
        end else begin
            o_sat <= vld_pipe[STAGES-1] & sat_c;
            if (vld_pipe[STAGES-1]) o_convolved_data <= pix_c;
        end
    end

    assign o_convolved_data_valid = vld_pipe[STAGES];
endmodule
